// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and constants for the two-requester shared-adder arbiter.
package adder_share_arbiter_pkg;

    localparam int unsigned DATA_W_DEFAULT = 64;
    localparam int unsigned ID_W           = 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_t;

endpackage

// File: rtl/adder_rr_pick.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module adder_rr_pick (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req_valid == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end
    end

endmodule

// File: rtl/sixtyfour_bit_carry_lookahead_adder.sv
// 64-bit adder built from 4-bit carry-lookahead groups with the group carries chained.
module sixtyfour_bit_carry_lookahead_adder (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    logic [63:0] g;
    logic [63:0] p;
    logic [64:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < 64; k += 4) begin
            c[k+1] = g[k] | (p[k] & c[k]);
            c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
            c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k])
                   | (p[k+2] & p[k+1] & p[k] & c[k]);
            c[k+4] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1])
                   | (p[k+3] & p[k+2] & p[k+1] & g[k])
                   | (p[k+3] & p[k+2] & p[k+1] & p[k] & c[k]);
        end
    end

    assign sum  = p ^ c[63:0];
    assign cout = c[64];

endmodule

// File: rtl/adder_share_arbiter.sv
// Arbitrates two requesters onto one shared 64-bit adder (IDLE -> EXEC -> RESP).
// Define ADDER_SHARE_FLAGS_EN to add the registered N/Z/C/V flag outputs.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_sub,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_sub,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_sum,
    output logic              rsp_cout
`ifdef ADDER_SHARE_FLAGS_EN
    ,
    output logic              rsp_n,
    output logic              rsp_z,
    output logic              rsp_c,
    output logic              rsp_v
`endif
);

    state_t            state_q;
    logic [ID_W-1:0]   last_q;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              sub_q;

    logic              accept_en;
    logic [1:0]        grant;
    logic              accept;
    logic              grant_id;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic              sel_sub;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W-1:0] add_sum;
    logic              add_cout;

    // Gated by reset_n so req_ready reads 0 while reset is held.
    assign accept_en = reset_n & ((state_q == StIdle) | ((state_q == StResp) & rsp_ready));

    adder_rr_pick u_rr_pick (
        .req_valid  (req_valid),
        .last_grant (last_q),
        .enable     (accept_en),
        .grant      (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign grant_id  = grant[1];
    assign sel_a     = grant_id ? req1_a   : req0_a;
    assign sel_b     = grant_id ? req1_b   : req0_b;
    assign sel_sub   = grant_id ? req1_sub : req0_sub;

    assign b_eff = sub_q ? ~b_q : b_q;

    sixtyfour_bit_carry_lookahead_adder u_adder (
        .a    (a_q),
        .b    (b_eff),
        .cin  (sub_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
`ifdef ADDER_SHARE_FLAGS_EN
            rsp_n     <= 1'b0;
            rsp_z     <= 1'b0;
            rsp_c     <= 1'b0;
            rsp_v     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        sub_q   <= sel_sub;
                        id_q    <= grant_id;
                        last_q  <= grant_id;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    rsp_sum   <= add_sum;
                    rsp_cout  <= add_cout;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
`ifdef ADDER_SHARE_FLAGS_EN
                    rsp_n     <= add_sum[DATA_W-1];
                    rsp_z     <= (add_sum == '0);
                    rsp_c     <= add_cout;
                    // Signed overflow: operands agree in sign, result does not.
                    rsp_v     <= (a_q[DATA_W-1] == b_eff[DATA_W-1]) &
                                 (add_sum[DATA_W-1] != a_q[DATA_W-1]);
`endif
                    state_q   <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (accept) begin
                            a_q     <= sel_a;
                            b_q     <= sel_b;
                            sub_q   <= sel_sub;
                            id_q    <= grant_id;
                            last_q  <= grant_id;
                            state_q <= StExec;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter (flag checks when
// ADDER_SHARE_FLAGS_EN is defined).
module tb_adder_share_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_sub, req1_sub;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_sum;
    logic        rsp_cout;
`ifdef ADDER_SHARE_FLAGS_EN
    logic        rsp_n, rsp_z, rsp_c, rsp_v;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_share_arbiter #(.DATA_W(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_sub  (req0_sub),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_sub  (req1_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
`ifdef ADDER_SHARE_FLAGS_EN
        ,
        .rsp_n     (rsp_n),
        .rsp_z     (rsp_z),
        .rsp_c     (rsp_c),
        .rsp_v     (rsp_v)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp_flags = {N, Z, C, V}
    task automatic run_op(input logic id, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic [63:0] exp_sum, input logic exp_cout,
                          input logic [3:0] exp_flags);
        logic [1:0] onehot;
        onehot = id ? 2'b10 : 2'b01;
        if (id) begin
            req1_a = a; req1_b = b; req1_sub = sub;
        end else begin
            req0_a = a; req0_b = b; req0_sub = sub;
        end
        req_valid = onehot;
        #1;
        check_eq("op_ready", {62'd0, req_ready}, {62'd0, onehot});
        tick();
        req_valid = 2'b00;
        check_eq("op_exec_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("op_exec_ready", {62'd0, req_ready}, 64'd0);
        tick();
        check_eq("op_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check_eq("op_sum", rsp_sum, exp_sum);
        check_eq("op_cout", {63'd0, rsp_cout}, {63'd0, exp_cout});
        check_eq("op_id", {63'd0, rsp_id}, {63'd0, id});
`ifdef ADDER_SHARE_FLAGS_EN
        check_eq("op_flags", {60'd0, rsp_n, rsp_z, rsp_c, rsp_v}, {60'd0, exp_flags});
`else
        if (exp_flags === 4'bxxxx) $display("unreachable");
`endif
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("op_idle_valid", {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        logic [1:0]  exp_oh;
        logic        exp_id;
        reset_n   = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        #1;
        check_eq("rst_ready", {62'd0, req_ready}, 64'd0);
        tick();
        check_eq("rst_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("rst_sum", rsp_sum, 64'd0);
        check_eq("rst_cout", {63'd0, rsp_cout}, 64'd0);
        check_eq("rst_id", {63'd0, rsp_id}, 64'd0);
`ifdef ADDER_SHARE_FLAGS_EN
        check_eq("rst_flags", {60'd0, rsp_n, rsp_z, rsp_c, rsp_v}, 64'd0);
`endif
        req_valid = 2'b00;
        reset_n   = 1'b1;
        tick();

        run_op(1'b0, 64'd5, 64'd3, 1'b0, 64'd8, 1'b0, 4'b0000);
        run_op(1'b1, 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'b1000);
        run_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0,
               4'b1001);
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 4'b0110);

        // Alternation from reset with both requesters always valid.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req0_a = 64'd10;  req0_b = 64'd1; req0_sub = 1'b0;
        req1_a = 64'd100; req1_b = 64'd1; req1_sub = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_id = i[0];
            exp_oh = exp_id ? 2'b10 : 2'b01;
            check_eq("alt_grant", {62'd0, req_ready}, {62'd0, exp_oh});
            tick();
            check_eq("alt_exec_valid", {63'd0, rsp_valid}, 64'd0);
            tick();
            check_eq("alt_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check_eq("alt_rsp_id", {63'd0, rsp_id}, {63'd0, exp_id});
            check_eq("alt_sum", rsp_sum, exp_id ? 64'd99 : 64'd11);
            check_eq("alt_cout", {63'd0, rsp_cout}, {63'd0, exp_id});
        end

        // Backpressure: hold the requester-1 result for 5 cycles.
        rsp_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_ready", {62'd0, req_ready}, 64'd0);
            check_eq("bp_valid", {63'd0, rsp_valid}, 64'd1);
            check_eq("bp_sum", rsp_sum, 64'd99);
            check_eq("bp_id", {63'd0, rsp_id}, 64'd1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_release_grant", {62'd0, req_ready}, 64'b01);
        tick();
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        check_eq("bp_exec_valid", {63'd0, rsp_valid}, 64'd0);

        // Reset during EXEC discards the operation.
        reset_n = 1'b0;
        #1;
        check_eq("rst_exec_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("rst_exec_ready", {62'd0, req_ready}, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check_eq("rst_no_phantom", {63'd0, rsp_valid}, 64'd0);
        req_valid = 2'b11;
        #1;
        check_eq("rst_first_grant", {62'd0, req_ready}, 64'b01);
        tick();
        req_valid = 2'b00;
        tick();
        check_eq("rst_after_id", {63'd0, rsp_id}, 64'd0);
        check_eq("rst_after_sum", rsp_sum, 64'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
